// File: rtl/axi_master_burst.sv
// ---------------------------------------------------------------------------
// axi_master_burst
//   Single-outstanding burst master. A user command (write or read, start
//   address, beats-1, id) is turned into one address transfer followed by
//   the data beats. The user write/read streams are passed straight through
//   to the bus data channels while the matching data state is active.
//
// Parameters
//   TIMEOUT : cycles without any handshake tolerated in a busy state
//   STRB    : constant byte strobe driven on WR_STRB
//
// Ports
//   clk, rst             : clock (rising edge), synchronous active-low reset
//   cmd_*                : command handshake (valid/ready, write, addr, len, id)
//   usr_w*               : user write-data stream into the master
//   usr_r*               : user read-data stream out of the master
//   done                 : one-cycle pulse when a transaction finishes
//   err                  : sticky error, cleared on the next command accept
//   WR_ADDR* / WR_LEN/ID : write-address channel
//   WR_DATA* / WR_STRB   : write-data channel, WR_BACK_ID returned by slave
//   RD_ADDR* / RD_LEN/ID : read-address channel
//   RD_DATA* / RD_BACK_ID: read-data channel
// ---------------------------------------------------------------------------
module axi_master_burst #(
  parameter int         TIMEOUT = 1024,
  parameter logic [3:0] STRB    = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic [3:0]  cmd_id,
  input  logic [31:0] usr_wdata,
  input  logic        usr_wvalid,
  output logic        usr_wready,
  output logic [31:0] usr_rdata,
  output logic        usr_rvalid,
  output logic        usr_rlast,
  input  logic        usr_rready,
  output logic        done,
  output logic        err,
  output logic [31:0] WR_ADDR,
  output logic [7:0]  WR_LEN,
  output logic [3:0]  WR_ID,
  output logic        WR_ADDR_VALID,
  input  logic        WR_ADDR_READY,
  output logic [31:0] WR_DATA,
  output logic [3:0]  WR_STRB,
  output logic        WR_DATA_VALID,
  output logic        WR_DATA_LAST,
  input  logic        WR_DATA_READY,
  input  logic [3:0]  WR_BACK_ID,
  output logic [31:0] RD_ADDR,
  output logic [7:0]  RD_LEN,
  output logic [3:0]  RD_ID,
  output logic        RD_ADDR_VALID,
  input  logic        RD_ADDR_READY,
  input  logic [31:0] RD_DATA,
  input  logic        RD_DATA_VALID,
  input  logic        RD_DATA_LAST,
  input  logic [3:0]  RD_BACK_ID,
  output logic        RD_DATA_READY
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WDATA = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [31:0]   r_addr;
  logic [7:0]    r_len;
  logic [3:0]    r_id;
  logic [8:0]    r_beat_cnt;
  logic [TW-1:0] r_timer;
  logic          r_err;

  logic w_cmd_fire;
  logic w_whs;
  logic w_rhs;
  logic w_at_last;
  logic w_busy;
  logic w_timeout;
  logic w_hs;
  logic w_set_err;

  // cmd_ready is also qualified by rst so it stays low during the reset
  // cycle itself and rises as soon as reset is released.
  assign cmd_ready  = (r_state == IDLE) && rst;
  assign w_cmd_fire = cmd_valid && cmd_ready;

  // The beat counter is one bit wider than len so that a 256-beat burst
  // can count its final beat without wrapping back to zero.
  assign w_at_last = (r_beat_cnt == {1'b0, r_len});
  assign w_whs     = (r_state == WDATA) && usr_wvalid && WR_DATA_READY;
  assign w_rhs     = (r_state == RDATA) && RD_DATA_VALID && usr_rready;
  assign w_busy    = (r_state == WADDR) || (r_state == WDATA) ||
                     (r_state == RADDR) || (r_state == RDATA);
  // Firing one count early means DONE is entered exactly TIMEOUT cycles
  // after the last handshake or state entry.
  assign w_timeout = (r_timer == TW'(TIMEOUT - 1));

  // Address channels always present the latched command; VALID qualifies it.
  assign WR_ADDR       = r_addr;
  assign WR_LEN        = r_len;
  assign WR_ID         = r_id;
  assign WR_ADDR_VALID = (r_state == WADDR);
  assign RD_ADDR       = r_addr;
  assign RD_LEN        = r_len;
  assign RD_ID         = r_id;
  assign RD_ADDR_VALID = (r_state == RADDR);

  // Data channels are straight pass-throughs gated by the data states.
  assign WR_STRB       = STRB;
  assign WR_DATA       = (r_state == WDATA) ? usr_wdata : 32'd0;
  assign WR_DATA_VALID = (r_state == WDATA) && usr_wvalid;
  assign WR_DATA_LAST  = (r_state == WDATA) && w_at_last;
  assign usr_wready    = (r_state == WDATA) && WR_DATA_READY;

  assign usr_rdata     = (r_state == RDATA) ? RD_DATA : 32'd0;
  assign usr_rvalid    = (r_state == RDATA) && RD_DATA_VALID;
  assign usr_rlast     = (r_state == RDATA) && RD_DATA_LAST;
  assign RD_DATA_READY = (r_state == RDATA) && usr_rready;

  assign done = (r_state == DONE);
  assign err  = r_err;

  // Next-state logic. A handshake always wins over an expiring timer in the
  // same cycle, since the transfer did make progress.
  always_comb begin
    w_next    = r_state;
    w_hs      = 1'b0;
    w_set_err = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cmd_fire) w_next = cmd_write ? WADDR : RADDR;
      end
      WADDR: begin
        if (WR_ADDR_READY) begin
          w_hs   = 1'b1;
          w_next = WDATA;
        end else if (w_timeout) begin
          w_set_err = 1'b1;
          w_next    = DONE;
        end
      end
      WDATA: begin
        if (w_whs) begin
          w_hs = 1'b1;
          if (w_at_last) begin
            w_next = DONE;
            if (WR_BACK_ID != r_id) w_set_err = 1'b1;
          end
        end else if (w_timeout) begin
          w_set_err = 1'b1;
          w_next    = DONE;
        end
      end
      RADDR: begin
        if (RD_ADDR_READY) begin
          w_hs   = 1'b1;
          w_next = RDATA;
        end else if (w_timeout) begin
          w_set_err = 1'b1;
          w_next    = DONE;
        end
      end
      RDATA: begin
        if (w_rhs) begin
          w_hs = 1'b1;
          if ((RD_BACK_ID != r_id) || (RD_DATA_LAST != w_at_last)) w_set_err = 1'b1;
          // Whichever end marker arrives first closes the burst; any further
          // slave beats are refused because RD_DATA_READY drops with RDATA.
          if (RD_DATA_LAST || w_at_last) w_next = DONE;
        end else if (w_timeout) begin
          w_set_err = 1'b1;
          w_next    = DONE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State, latched command, beat counter, stall timer and sticky error.
  // The transfer direction is not stored; it is carried by the state path.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_addr     <= 32'd0;
      r_len      <= 8'd0;
      r_id       <= 4'd0;
      r_beat_cnt <= 9'd0;
      r_timer    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;

      if (w_cmd_fire) begin
        r_addr     <= cmd_addr;
        r_len      <= cmd_len;
        r_id       <= cmd_id;
        r_beat_cnt <= 9'd0;
        r_err      <= 1'b0;
      end else begin
        if (w_whs || w_rhs) r_beat_cnt <= r_beat_cnt + 9'd1;
        if (w_set_err) r_err <= 1'b1;
      end

      // The stall timer restarts on every handshake and on every state
      // change, so each busy state gets its own full TIMEOUT window.
      if (!w_busy || w_hs || (w_next != r_state)) r_timer <= '0;
      else r_timer <= r_timer + TW'(1);
    end
  end

endmodule

// File: doc/axi_master_burst.md
AXI_MASTER_BURST -- requirements
Module: axi_master_burst

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024: stall limit in cycles with no handshake in any busy state.
REQ-002 SHALL have parameter STRB, default 4'hF: constant value driven on WR_STRB.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-low (0 = reset).
REQ-005 SHALL have ports cmd_valid (in, 1), cmd_ready (out, 1), cmd_write (in, 1; 1 = write, 0 = read), cmd_addr (in, 32), cmd_len (in, 8; beats-1), cmd_id (in, 4): command handshake.
REQ-006 SHALL have ports usr_wdata (in, 32), usr_wvalid (in, 1), usr_wready (out, 1): user write-data stream.
REQ-007 SHALL have ports usr_rdata (out, 32), usr_rvalid (out, 1), usr_rlast (out, 1), usr_rready (in, 1): user read-data stream.
REQ-008 SHALL have ports done (out, 1; one-cycle pulse) and err (out, 1; sticky).
REQ-009 SHALL have write-address outputs WR_ADDR (32), WR_LEN (8), WR_ID (4), WR_ADDR_VALID (1), and input WR_ADDR_READY (1).
REQ-010 SHALL have write-data outputs WR_DATA (32), WR_STRB (4), WR_DATA_VALID (1), WR_DATA_LAST (1), and inputs WR_DATA_READY (1) and WR_BACK_ID (4).
REQ-011 SHALL have read-address outputs RD_ADDR (32), RD_LEN (8), RD_ID (4), RD_ADDR_VALID (1), and input RD_ADDR_READY (1).
REQ-012 SHALL have read-data inputs RD_DATA (32), RD_DATA_VALID (1), RD_DATA_LAST (1), RD_BACK_ID (4), and output RD_DATA_READY (1).

Function
REQ-013 SHALL implement the FSM states IDLE, WADDR, WDATA, RADDR, RDATA and DONE, with one transaction outstanding at a time.
REQ-014 SHALL assert cmd_ready only in IDLE; on cmd_valid&&cmd_ready it SHALL latch addr/len/id/write, clear err and beat_cnt, and go to WADDR if write, else RADDR.
REQ-015 SHALL drive WR_ADDR/WR_LEN/WR_ID (resp. RD_*) from the latched command, held stable while *_ADDR_VALID is high.
REQ-016 SHALL hold WR_ADDR_VALID (resp. RD_ADDR_VALID) high in WADDR (RADDR) until the READY handshake, then go to WDATA (RDATA) on the next edge.
REQ-017 In WDATA, SHALL drive WR_DATA=usr_wdata, WR_DATA_VALID=usr_wvalid and usr_wready=WR_DATA_READY combinationally; both SHALL be 0 outside WDATA.
REQ-018 SHALL drive WR_DATA_LAST=(beat_cnt==len) while in WDATA, and SHALL increment the 9-bit beat_cnt on every data handshake.
REQ-019 On the last write handshake, SHALL go to DONE and set err if WR_BACK_ID!=latched id.
REQ-020 In RDATA, SHALL pass usr_rdata=RD_DATA, usr_rvalid=RD_DATA_VALID, usr_rlast=RD_DATA_LAST and RD_DATA_READY=usr_rready, all gated to 0 outside RDATA.
REQ-021 On each read handshake, SHALL set err if RD_BACK_ID!=id, or if RD_DATA_LAST!=(beat_cnt==len).
REQ-022 SHALL leave RDATA for DONE on the first handshake with RD_DATA_LAST=1 or beat_cnt==len, whichever comes first; beats beyond that SHALL not be accepted.
REQ-023 SHALL count the cycles without a handshake in each of WADDR/WDATA/RADDR/RDATA with a counter cleared on every handshake and on state entry.
REQ-024 When that counter reaches TIMEOUT, SHALL set err, drop all VALID/READY outputs, and go to DONE.
REQ-025 In DONE, SHALL assert done for exactly one cycle and then return to IDLE.
REQ-026 SHALL support cmd_len=255 (256 beats) without beat_cnt overflow and cmd_len=0 (LAST on the first beat).
REQ-027 SHALL not wrap addresses: address wrap is the responder's concern and the address is issued once per burst.

Reset
REQ-028 While rst=0 at a clock edge, SHALL enter IDLE, zero beat_cnt, the timeout counter and the latched command, and drive err=0, done=0, every VALID/READY output=0 and cmd_ready=0.
REQ-029 SHALL assert cmd_ready in the first cycle after rst returns to 1.
REQ-030 A reset asserted mid-burst SHALL abort the transaction in the same edge with no done pulse.

Verification
REQ-031 Write addr=0x10, len=3, id=5, slave ready after 3 cycles -> 4 beats with LAST on the 4th only, done pulse, err=0.
REQ-032 Read addr=0x10, len=3 after REQ-031 -> usr_rdata equals the written words in order, usr_rlast on beat 4, done, err=0.
REQ-033 Read len=0 -> single beat with usr_rlast=1 and done two cycles after the handshake.
REQ-034 Slave returns RD_BACK_ID=6 for id=5 -> err=1 after done, cleared on the next cmd accept.
REQ-035 Slave never asserts WR_DATA_READY, TIMEOUT=16 -> err=1 and done 16 cycles after WDATA entry, WR_DATA_VALID low afterward.
REQ-036 rst=0 during beat 2 of a len=7 read -> RD_DATA_READY=0 next cycle, no done, cmd_ready=1 after release.
